// File: rtl/qlab5_mem_streamer.sv
// Command-driven mover between valid/ready streams and a single-port memory
// with 1-cycle read latency; it is the only master on that port.
module qlab5_mem_streamer #(
  parameter int DEPTH    = 1024,
  parameter int OUT_FIFO = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_dir,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic          sink_valid,
  output logic          sink_ready,
  input  logic [31:0]   sink_data,
  output logic          src_valid,
  input  logic          src_ready,
  output logic [31:0]   src_data,
  output logic [AW-1:0] mem_address,
  output logic [3:0]    mem_byteenable,
  output logic          mem_chipselect,
  output logic          mem_write,
  output logic [31:0]   mem_writedata,
  output logic          mem_clken,
  input  logic [31:0]   mem_readdata,
  output logic          busy,
  output logic          done
);
  localparam int PW = (OUT_FIFO > 1) ? $clog2(OUT_FIFO) : 1;
  localparam int CW = $clog2(OUT_FIFO + 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
  state_t state, state_n;

  logic [AW-1:0] addr;
  logic [LW-1:0] issue_left, dlv_left;
  logic          in_flight;
  logic [31:0]   fifo_mem [OUT_FIFO];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, occ;
  logic          wr_fire, rd_issue, pop, fifo_pop, push;

  function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
    return (p == PW'(OUT_FIFO - 1)) ? '0 : p + PW'(1);
  endfunction

  assign wr_fire  = sink_ready & sink_valid;
  // every in-flight read already owns a FIFO slot, so the buffer cannot overflow
  assign occ      = count + CW'(in_flight);
  assign rd_issue = (state == READ) && (issue_left != '0) && (occ < CW'(OUT_FIFO));

  // returning read data bypasses an empty FIFO so a word can leave the cycle it lands
  assign src_valid = (count != '0) || in_flight;
  assign src_data  = (count != '0) ? fifo_mem[rd_ptr] : mem_readdata;
  assign pop       = src_valid & src_ready;
  assign fifo_pop  = pop && (count != '0);
  assign push      = in_flight && !(pop && (count == '0));

  assign mem_chipselect = wr_fire | rd_issue;
  assign mem_write      = wr_fire;
  assign mem_address    = addr;
  assign mem_writedata  = sink_data;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cmd_valid) state_n = (cmd_len == '0) ? DONE : (cmd_dir ? READ : WRITE);
      WRITE:   if (wr_fire && issue_left == LW'(1)) state_n = DONE;
      READ:    if (pop && dlv_left == LW'(1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      sink_ready <= 1'b0;
      addr       <= '0;
      issue_left <= '0;
      dlv_left   <= '0;
      in_flight  <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      state      <= state_n;
      cmd_ready  <= (state_n == IDLE);
      busy       <= (state_n != IDLE);
      done       <= (state_n == DONE);
      sink_ready <= (state_n == WRITE);
      if (state == IDLE && cmd_valid) begin
        addr       <= cmd_addr;
        issue_left <= cmd_len;
        dlv_left   <= cmd_len;
      end else if (wr_fire || rd_issue) begin
        addr       <= addr + AW'(1);
        issue_left <= issue_left - LW'(1);
      end
      if (pop) dlv_left <= dlv_left - LW'(1);
      in_flight <= rd_issue;
      if (push) wr_ptr <= nxt_ptr(wr_ptr);
      if (fifo_pop) rd_ptr <= nxt_ptr(rd_ptr);
      count <= count + CW'(push) - CW'(fifo_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_readdata;
  end
endmodule
